// File: rtl/acc_norm_round_if.sv
// Bus bundle for the accumulator normalise-and-round stage: an input beat channel and an output
// result channel, each with valid/ready.
interface acc_norm_round_if #(
    parameter int WIDTH = 107,
    parameter int EXP_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             sign;
    logic [EXP_W-1:0] exp_in;
    logic [6:0]       zero_cnt;
    logic             lza_inv;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_ovf;
    logic             out_unf;

    modport slave (
        input  in_valid, sum, sign, exp_in, zero_cnt, lza_inv, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf
    );

    modport master (
        output in_valid, sum, sign, exp_in, zero_cnt, lza_inv, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf
    );
endinterface

// File: rtl/acc_norm_round.sv
// Two-stage normalise-and-round from the accumulator sum to packed FP32 (round-to-nearest-even).
// Optional macro ACC_NORM_SAT_EN: overflow saturates to max finite instead of infinity.
module acc_norm_round #(
    parameter int WIDTH = 107,
    parameter int EXP_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    acc_norm_round_if.slave   bus
);
    localparam int EW = EXP_W + 1;
    localparam logic signed [EW-1:0] E_ZERO = EW'(0);
    localparam logic signed [EW-1:0] E_ONE  = EW'(1);
    localparam logic signed [EW-1:0] E_MAX  = EW'(255);
`ifdef ACC_NORM_SAT_EN
    localparam logic [30:0] OVF_MAG = 31'h7F7FFFFF;
`else
    localparam logic [30:0] OVF_MAG = 31'h7F800000;
`endif

    // Handshake: a beat moves when valid && ready on the same edge. Stage 1 loads whenever it is
    // empty or stage 2 is draining; stage 2 loads whenever it is empty or downstream takes it.
    logic s2_free;
    logic in_ready;

    logic                    s1_v_q;
    logic                    s1_sign_q;
    logic                    s1_lza_q;
    logic [WIDTH-1:0]        s1_shifted_q;
    logic signed [EW-1:0]    s1_e1_q;
    logic [WIDTH-1:0]        shifted_d;
    logic signed [EW-1:0]    e1_d;

    logic                    s2_v_q;
    logic [31:0]             s2_data_q;
    logic                    s2_ovf_q;
    logic                    s2_unf_q;
    logic [31:0]             s2_data_d;
    logic                    s2_ovf_d;
    logic                    s2_unf_d;

    assign s2_free      = !s2_v_q || bus.out_ready;
    assign in_ready     = !s1_v_q || s2_free;
    assign bus.in_ready = in_ready;

    always_comb begin
        shifted_d = bus.sum << bus.zero_cnt;
        e1_d      = $signed({bus.exp_in[EXP_W-1], bus.exp_in})
                  - $signed({{(EW-7){1'b0}}, bus.zero_cnt});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q       <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_lza_q     <= 1'b0;
            s1_shifted_q <= '0;
            s1_e1_q      <= '0;
        end else if (in_ready) begin
            s1_v_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q    <= bus.sign;
                s1_lza_q     <= bus.lza_inv;
                s1_shifted_q <= shifted_d;
                s1_e1_q      <= e1_d;
            end
        end
    end

    logic [WIDTH-1:0]     norm;
    logic signed [EW-1:0] e2;
    logic signed [EW-1:0] e_f;
    logic                 guard_b;
    logic                 sticky_b;
    logic                 round_up;
    logic [23:0]          man_r;
    logic [22:0]          man_f;
    logic                 is_zero;

    // The anticipator may undershoot by one bit; a leading zero after the first shift costs one more.
    always_comb begin
        norm      = s1_shifted_q[WIDTH-1] ? s1_shifted_q : (s1_shifted_q << 1);
        e2        = s1_shifted_q[WIDTH-1] ? s1_e1_q : (s1_e1_q - E_ONE);
        is_zero   = s1_lza_q || !norm[WIDTH-1];
        guard_b   = norm[WIDTH-25];
        sticky_b  = |norm[WIDTH-26:0];
        round_up  = guard_b && (sticky_b || norm[WIDTH-24]);
        man_r     = {1'b0, norm[WIDTH-2:WIDTH-24]} + {23'b0, round_up};
        man_f     = man_r[23] ? 23'b0 : man_r[22:0];
        e_f       = e2 + (man_r[23] ? E_ONE : E_ZERO);
        s2_data_d = {s1_sign_q, 31'b0};
        s2_ovf_d  = 1'b0;
        s2_unf_d  = 1'b0;
        if (is_zero) begin
            s2_data_d = {s1_sign_q, 31'b0};
        end else if (e_f <= E_ZERO) begin
            s2_unf_d  = 1'b1;
        end else if (e_f >= E_MAX) begin
            s2_ovf_d  = 1'b1;
            s2_data_d = {s1_sign_q, OVF_MAG};
        end else begin
            s2_data_d = {s1_sign_q, e_f[7:0], man_f};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_ovf_q  <= 1'b0;
            s2_unf_q  <= 1'b0;
        end else if (s2_free) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_data_q <= s2_data_d;
                s2_ovf_q  <= s2_ovf_d;
                s2_unf_q  <= s2_unf_d;
            end
        end
    end

    assign bus.out_valid = s2_v_q;
    assign bus.out_data  = s2_data_q;
    assign bus.out_ovf   = s2_ovf_q;
    assign bus.out_unf   = s2_unf_q;
endmodule

// File: tb/tb_acc_norm_round.sv
// Directed bench for acc_norm_round: driver pushes hand-computed results, monitor pops and compares.
module tb_acc_norm_round;
    localparam int WIDTH = 107;
    localparam int EXP_W = 10;
`ifdef ACC_NORM_SAT_EN
    localparam logic [31:0] OVF_POS = 32'h7F7FFFFF;
`else
    localparam logic [31:0] OVF_POS = 32'h7F800000;
`endif

    logic clk;
    logic rst_n;
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    int   accepted  = 0;
    logic [33:0] exp_q[$];

    acc_norm_round_if #(.WIDTH(WIDTH), .EXP_W(EXP_W)) bus ();
    acc_norm_round #(.WIDTH(WIDTH), .EXP_W(EXP_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, check_cnt);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] expv);
        check_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    function automatic logic [WIDTH-1:0] bit_at(input int n);
        logic [WIDTH-1:0] v;
        v = '0;
        v[n] = 1'b1;
        return v;
    endfunction

    // driver
    task automatic send(input logic [WIDTH-1:0] s, input logic sg, input logic [EXP_W-1:0] e,
                        input logic [6:0] zc, input logic lz,
                        input logic [31:0] ed, input logic eo, input logic eu);
        int waits;
        waits = 0;
        bus.in_valid = 1'b1;
        bus.sum      = s;
        bus.sign     = sg;
        bus.exp_in   = e;
        bus.zero_cnt = zc;
        bus.lza_inv  = lz;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waits++;
            if (waits > 200) break;
        end
        if (waits > 200) begin
            check("send_timeout", 34'd1, 34'd0);
        end else begin
            exp_q.push_back({eo, eu, ed});
            accepted++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // scoreboard monitor plus stall-stability tracking
    logic [33:0] held;
    logic        held_v = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v <= 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {bus.out_ovf, bus.out_unf, bus.out_data}, 34'h3FFFFFFFF);
                end else begin
                    check("result", {bus.out_ovf, bus.out_unf, bus.out_data}, exp_q.pop_front());
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (held_v) check("stall_stable", {bus.out_ovf, bus.out_unf, bus.out_data}, held);
                held   <= {bus.out_ovf, bus.out_unf, bus.out_data};
                held_v <= 1'b1;
            end else begin
                held_v <= 1'b0;
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] s;
        bus.in_valid  = 1'b0;
        bus.sum       = '0;
        bus.sign      = 1'b0;
        bus.exp_in    = '0;
        bus.zero_cnt  = '0;
        bus.lza_inv   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", {33'b0, bus.in_ready}, 34'd1);
        check("reset_outputs", {bus.out_valid, bus.out_ovf, bus.out_unf, bus.out_data}, 35'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1.0 with latency check
        send(bit_at(106), 1'b0, 10'd127, 7'd0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        check("latency_not_early", {33'b0, bus.out_valid}, 34'd0);
        @(posedge clk);
        #1;
        check("latency_valid", {33'b0, bus.out_valid}, 34'd1);
        repeat (2) @(posedge clk);
        #1;

        // normal values, correction, rounding
        send(bit_at(80), 1'b0, 10'd150, 7'd26, 1'b0, 32'h3E000000, 1'b0, 1'b0);
        send(bit_at(79), 1'b0, 10'd150, 7'd26, 1'b0, 32'h3D800000, 1'b0, 1'b0);
        s = '0;
        for (int i = 82; i <= 106; i++) s[i] = 1'b1;
        send(s, 1'b0, 10'd127, 7'd0, 1'b0, 32'h40000000, 1'b0, 1'b0);
        send(bit_at(106) | bit_at(82), 1'b0, 10'd127, 7'd0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        send(bit_at(106) | bit_at(83) | bit_at(82), 1'b0, 10'd127, 7'd0, 1'b0, 32'h3F800002, 1'b0, 1'b0);
        send(bit_at(106) | bit_at(82) | bit_at(0), 1'b0, 10'd127, 7'd0, 1'b0, 32'h3F800001, 1'b0, 1'b0);
        send(bit_at(106), 1'b1, 10'd128, 7'd0, 1'b0, 32'hC0000000, 1'b0, 1'b0);

        // range limits and zero cases
        send(bit_at(106), 1'b0, 10'd255, 7'd0, 1'b0, OVF_POS, 1'b1, 1'b0);
        send(s, 1'b1, 10'd254, 7'd0, 1'b0, {1'b1, OVF_POS[30:0]}, 1'b1, 1'b0);
        send(bit_at(96), 1'b0, 10'd5, 7'd10, 1'b0, 32'h00000000, 1'b0, 1'b1);
        send(bit_at(96), 1'b1, 10'd5, 7'd10, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send(bit_at(106), 1'b0, 10'd1, 7'd0, 1'b0, 32'h00800000, 1'b0, 1'b0);
        send(bit_at(105), 1'b0, 10'd1, 7'd0, 1'b0, 32'h00000000, 1'b0, 1'b1);
        send(bit_at(106), 1'b0, 10'h3FD, 7'd0, 1'b0, 32'h00000000, 1'b0, 1'b1);
        send(bit_at(106), 1'b1, 10'd127, 7'd0, 1'b1, 32'h80000000, 1'b0, 1'b0);
        send(WIDTH'(5), 1'b0, 10'd300, 7'd107, 1'b0, 32'h00000000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // back-pressure: only two beats fit, outputs hold, then drain back to back
        bus.out_ready = 1'b0;
        accepted = 0;
        fork
            begin
                send(bit_at(106), 1'b0, 10'd127, 7'd0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
                send(bit_at(106), 1'b0, 10'd128, 7'd0, 1'b0, 32'h40000000, 1'b0, 1'b0);
                send(bit_at(106), 1'b0, 10'd129, 7'd0, 1'b0, 32'h40800000, 1'b0, 1'b0);
                send(bit_at(106), 1'b1, 10'd130, 7'd0, 1'b0, 32'hC1000000, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #2;
                check("bp_accepted", 34'(accepted), 34'd2);
                check("bp_in_ready_low", {33'b0, bus.in_ready}, 34'd0);
                bus.out_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_back_to_back", {33'b0, bus.out_valid}, 34'd1);
                end
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("drain_empty", 34'(exp_q.size()), 34'd0);

        // reset mid-stream discards in-flight beats
        bus.out_ready = 1'b0;
        send(bit_at(106), 1'b0, 10'd127, 7'd0, 1'b0, 32'h3F800000, 1'b0, 1'b0);
        send(bit_at(106), 1'b0, 10'd128, 7'd0, 1'b0, 32'h40000000, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("reset_async_valid", {33'b0, bus.out_valid}, 34'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("reset_in_ready_after", {33'b0, bus.in_ready}, 34'd1);
        @(posedge clk);
        #1;
        send(bit_at(105), 1'b1, 10'd127, 7'd0, 1'b0, 32'hBF000000, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        check("final_empty", 34'(exp_q.size()), 34'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
